// File: rtl/loader_pkg.sv
// Shared types and constants for the program image loader.
// The length header is big-endian (first byte is the MSB), the same byte order as the decode constant field.
package loader_pkg;

   localparam int LEN_BYTES = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE,
      S_ERR
   } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams a length-prefixed program image into the instruction RAM while holding the core.
// Optional trailing checksum byte is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MEM_BYTES = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [31:0]       bytes_loaded
);

   loader_state_t state;
   logic [31:0]   len_sr;
   logic [1:0]    hdr_cnt;
   logic [31:0]   next_len;
   logic          accept;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0]    sum;
`endif

   always_comb begin
      in_ready = 1'b0;
      case (state)
         S_LEN, S_DATA: in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHK:         in_ready = 1'b1;
`endif
         default:       in_ready = 1'b0;
      endcase
   end

   assign cpu_hold = in_ready;
   assign accept   = in_valid && in_ready;
   assign next_len = {len_sr[23:0], in_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= S_IDLE;
         len_sr       <= '0;
         hdr_cnt      <= '0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         done         <= 1'b0;
         error        <= 1'b0;
         bytes_loaded <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum          <= '0;
`endif
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state        <= S_LEN;
                  done         <= 1'b0;
                  error        <= 1'b0;
                  bytes_loaded <= '0;
                  len_sr       <= '0;
                  hdr_cnt      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum          <= '0;
`endif
               end
            end
            S_LEN: begin
               if (accept) begin
                  len_sr  <= next_len;
                  hdr_cnt <= hdr_cnt + 2'd1;
                  if (hdr_cnt == 2'(LEN_BYTES - 1)) begin
                     // Oversize is rejected here so the payload address can never wrap.
                     if (next_len == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state <= S_CHK;
`else
                        state <= S_DONE;
                        done  <= 1'b1;
`endif
                     end else if (next_len > 32'(MEM_BYTES)) begin
                        state <= S_ERR;
                        error <= 1'b1;
                     end else begin
                        state <= S_DATA;
                     end
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  wr_en        <= 1'b1;
                  wr_addr      <= bytes_loaded[ADDR_W-1:0];
                  wr_data      <= in_data;
                  bytes_loaded <= bytes_loaded + 32'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  sum          <= sum + in_data;
`endif
                  if (bytes_loaded + 32'd1 == len_sr) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     state <= S_CHK;
`else
                     state <= S_DONE;
                     done  <= 1'b1;
`endif
                  end
               end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (accept) begin
                  if (in_data == sum) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected RAM writes go into a scoreboard queue as bytes are driven
// and are popped by a negedge monitor; define PROGRAM_LOADER_CHECKSUM_EN to cover the checksum build.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        cpu_hold;
   logic        done;
   logic        error;
   logic [31:0] bytes_loaded;

   int          checks = 0;
   int          fails  = 0;
   logic [15:0] sb[$];
   logic [7:0]  exp_addr;
   logic [7:0]  exp_sum;
   logic        exp_acc = 1'b0;
   logic        acc_q   = 1'b0;
   logic        mon_on  = 1'b0;

   program_loader #(.ADDR_W(8), .MEM_BYTES(256)) dut (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_hold(cpu_hold), .done(done), .error(error), .bytes_loaded(bytes_loaded)
   );

   always #5 clk = ~clk;

   // A payload byte accepted this cycle must show up as a write in the next one, unless reset intervenes.
   always @(posedge clk) acc_q <= exp_acc && !reset;

   always @(negedge clk) begin
      if (mon_on) begin
         checks++;
         assert (wr_en === acc_q)
         else begin
            fails++;
            $error("FAIL wr_en_timing: observed %0b expected %0b at %0t", wr_en, acc_q, $time);
         end
         if (acc_q && wr_en === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
               fails++;
               $error("FAIL sb_underflow: observed write %0h:%0h expected none", wr_addr, wr_data);
            end else begin
               automatic logic [15:0] e = sb.pop_front();
               assert ({wr_addr, wr_data} === e)
               else begin
                  fails++;
                  $error("FAIL wr_addr_data: observed %0h expected %0h", {wr_addr, wr_data}, e);
               end
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      exp_acc  = 1'b0;
      repeat (n) step();
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit payload);
      in_valid = 1'b1;
      in_data  = b;
      exp_acc  = payload;
      if (payload) begin
         sb.push_back({exp_addr, b});
         exp_addr = exp_addr + 8'd1;
         exp_sum  = exp_sum + b;
      end
      step();
      in_valid = 1'b0;
      exp_acc  = 1'b0;
   endtask

   task automatic doStart();
      start = 1'b1;
      step();
      start    = 1'b0;
      exp_addr = 8'd0;
      exp_sum  = 8'd0;
   endtask

   task automatic sendHeader(input logic [31:0] len);
      applyStimulus(len[31:24], 1'b0);
      applyStimulus(len[23:16], 1'b0);
      applyStimulus(len[15:8],  1'b0);
      applyStimulus(len[7:0],   1'b0);
   endtask

   // Stalled loads also pulse start mid-payload, which the loader must ignore.
   task automatic loadImage(input logic [7:0] img[$], input bit stall, input bit bad_sum);
      doStart();
      sendHeader(32'(img.size()));
      for (int i = 0; i < img.size(); i++) begin
         if (stall && i > 0) begin
            in_valid = 1'b0;
            start    = (i == 2);
            step();
            start = 1'b0;
            step();
         end
         applyStimulus(img[i], 1'b1);
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      applyStimulus(bad_sum ? exp_sum + 8'd1 : exp_sum, 1'b0);
`endif
   endtask

   initial begin
      automatic logic [7:0] img[$];
      automatic logic [7:0] big[$];
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      exp_addr = 8'd0;
      exp_sum  = 8'd0;
      step();
      start    = 1'b1;
      in_valid = 1'b1;
      step();
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_wr_en", wr_en, 0);
      checkOutput("rst_cpu_hold", cpu_hold, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_error", error, 0);
      checkOutput("rst_wr_addr", wr_addr, 0);
      checkOutput("rst_wr_data", wr_data, 0);
      checkOutput("rst_bytes_loaded", bytes_loaded, 0);
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      mon_on   = 1'b1;
      step();

      $display("[TB] basic load");
      img = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h06, 8'h20, 8'h20, 8'hFF};
      doStart();
      checkOutput("len_cpu_hold", cpu_hold, 1);
      checkOutput("len_in_ready", in_ready, 1);
      sendHeader(32'd8);
      for (int i = 0; i < 7; i++) applyStimulus(img[i], 1'b1);
      checkOutput("data_cpu_hold", cpu_hold, 1);
      checkOutput("data_done", done, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      applyStimulus(img[7], 1'b1);
      checkOutput("chk_cpu_hold", cpu_hold, 1);
      applyStimulus(exp_sum, 1'b0);
`else
      applyStimulus(img[7], 1'b1);
`endif
      checkOutput("basic_done", done, 1);
      checkOutput("basic_cpu_hold", cpu_hold, 0);
      checkOutput("basic_in_ready", in_ready, 0);
      checkOutput("basic_bytes", bytes_loaded, 8);
      applyStimulus(8'hEE, 1'b0);
      idle(1);
      checkOutput("basic_sb_empty", sb.size(), 0);

      $display("[TB] stalled load");
      loadImage(img, 1'b1, 1'b0);
      checkOutput("stall_done", done, 1);
      checkOutput("stall_bytes", bytes_loaded, 8);
      idle(1);
      checkOutput("stall_sb_empty", sb.size(), 0);

      $display("[TB] oversize header");
      doStart();
      checkOutput("restart_clears_done", done, 0);
      sendHeader(32'h0000_0101);
      checkOutput("over_error", error, 1);
      checkOutput("over_in_ready", in_ready, 0);
      checkOutput("over_cpu_hold", cpu_hold, 0);
      applyStimulus(8'h55, 1'b0);
      applyStimulus(8'h66, 1'b0);
      checkOutput("over_bytes", bytes_loaded, 0);
      checkOutput("over_error_sticky", error, 1);

      $display("[TB] maximum-size load");
      big = {};
      for (int i = 0; i < 256; i++) big.push_back(8'(i) ^ 8'h5A);
      loadImage(big, 1'b0, 1'b0);
      checkOutput("max_done", done, 1);
      checkOutput("max_error", error, 0);
      checkOutput("max_bytes", bytes_loaded, 256);
      idle(1);
      checkOutput("max_sb_empty", sb.size(), 0);

      $display("[TB] zero length");
      doStart();
      sendHeader(32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      checkOutput("zero_chk_hold", cpu_hold, 1);
      checkOutput("zero_chk_done", done, 0);
      applyStimulus(8'h00, 1'b0);
      checkOutput("zero_done", done, 1);
      doStart();
      sendHeader(32'd0);
      applyStimulus(8'h01, 1'b0);
      checkOutput("zero_bad_error", error, 1);
      checkOutput("zero_bad_done", done, 0);
`else
      checkOutput("zero_done", done, 1);
      checkOutput("zero_cpu_hold", cpu_hold, 0);
`endif
      checkOutput("zero_bytes", bytes_loaded, 0);

      $display("[TB] reset mid-load");
      doStart();
      sendHeader(32'd8);
      for (int i = 0; i < 3; i++) applyStimulus(img[i], 1'b1);
      reset    = 1'b1;
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = img[3];
      step();
      checkOutput("midrst_cpu_hold", cpu_hold, 0);
      checkOutput("midrst_in_ready", in_ready, 0);
      checkOutput("midrst_wr_en", wr_en, 0);
      checkOutput("midrst_bytes", bytes_loaded, 0);
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      step();
      checkOutput("midrst_idle_hold", cpu_hold, 0);
      checkOutput("midrst_sb_empty", sb.size(), 0);
      loadImage(img, 1'b0, 1'b0);
      checkOutput("reload_done", done, 1);
      checkOutput("reload_bytes", bytes_loaded, 8);
      idle(1);
      checkOutput("reload_sb_empty", sb.size(), 0);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      $display("[TB] checksum trailer");
      img = '{8'h10, 8'h20, 8'h30};
      loadImage(img, 1'b0, 1'b0);
      checkOutput("sum_good_done", done, 1);
      checkOutput("sum_good_bytes", bytes_loaded, 3);
      loadImage(img, 1'b0, 1'b1);
      checkOutput("sum_bad_error", error, 1);
      checkOutput("sum_bad_done", done, 0);
      checkOutput("sum_bad_bytes", bytes_loaded, 3);
      idle(1);
      checkOutput("sum_sb_empty", sb.size(), 0);
`endif

      idle(2);
      $display("[TB] %0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
